// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter_pkg
// Brief   : Shared constants and helpers for the dcfifo write-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_wr_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // FSM encodings for the arbiter
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Modular add for indices already below n (a < n, b < n)
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter_if
// Brief   : Producer-side request bus plus dcfifo write-side signals.
//           master = arbiter, slave = producers / FIFO environment.
// Revision: 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int NREQ_L = $clog2(NREQ);

  logic [NREQ-1:0]       valid;
  logic [NREQ*WIDTH-1:0] din_flat;
  logic [NREQ-1:0]       ready;
  logic                  full;
  logic                  wr;
  logic [WIDTH-1:0]      dout;
  logic [NREQ_L-1:0]     gnt_id;
  logic                  busy;

  modport master (
    input  valid, din_flat, full,
    output ready, wr, dout, gnt_id, busy
  );

  modport slave (
    output valid, din_flat, full,
    input  ready, wr, dout, gnt_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter_rr_pick
// Brief   : Combinational round-robin picker: first set bit of req searching
//           upward from ptr with wrap at NREQ.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int c_NREQ_L = $clog2(NREQ);

  // Scan farthest-first so the candidate nearest ptr overwrites the rest
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_add(int'(ptr), k, NREQ)]) begin
        idx = c_NREQ_L'(wrap_add(int'(ptr), k, NREQ));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter
// Brief   : Shares one dcfifo write port among NREQ producers. Round-robin
//           grants held for up to BURST beats; one-cycle arbitration bubble.
//           Optional macro FIFO_WR_ARB_PRIO_EN: requester 0 always wins in
//           IDLE and does not advance the round-robin pointer.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BURST = 4
) (
  input  logic             clock,
  input  logic             reset,
  fifo_wr_arbiter_if.master bus
);
  localparam int                  c_NREQ_L    = $clog2(NREQ);
  localparam int                  c_BEAT_W    = $clog2(BURST) + 1;
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BURST - 1);

  logic [0:0]          r_state,    w_state_nxt;
  logic [c_NREQ_L-1:0] r_gnt_id,   w_gnt_id_nxt;
  logic [c_BEAT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [c_NREQ_L-1:0] r_rr_ptr,   w_rr_ptr_nxt;

  logic [NREQ-1:0]     w_req;
  logic                w_any;
  logic [c_NREQ_L-1:0] w_pick;
  logic                w_sel_any;
  logic [c_NREQ_L-1:0] w_sel;
  logic [c_NREQ_L-1:0] w_rr_inc;
  logic [c_NREQ_L-1:0] w_rr_after;
  logic                w_gnt_valid;
  logic                w_xfer;

  fifo_wr_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req (w_req),
    .ptr (r_rr_ptr),
    .any (w_any),
    .idx (w_pick)
  );

  assign w_rr_inc    = c_NREQ_L'(wrap_add(int'(r_gnt_id), 1, NREQ));
  assign w_gnt_valid = bus.valid[r_gnt_id];
  assign w_xfer      = (r_state == ST_GRANT) && w_gnt_valid && !bus.full;

`ifdef FIFO_WR_ARB_PRIO_EN
  // Requester 0 bypasses the rotation; the others share it
  assign w_req      = {bus.valid[NREQ-1:1], 1'b0};
  assign w_sel_any  = bus.valid[0] | w_any;
  assign w_sel      = bus.valid[0] ? '0 : w_pick;
  assign w_rr_after = (r_gnt_id == '0) ? r_rr_ptr : w_rr_inc;
`else
  assign w_req      = bus.valid;
  assign w_sel_any  = w_any;
  assign w_sel      = w_pick;
  assign w_rr_after = w_rr_inc;
`endif

  // State and grant bookkeeping registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gnt_id   <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, count beats / release in GRANT
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_id_nxt   = r_gnt_id;
    w_beat_cnt_nxt = r_beat_cnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_any) begin
          w_state_nxt    = ST_GRANT;
          w_gnt_id_nxt   = w_sel;
          w_beat_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (!w_gnt_valid) begin
          // Requester withdrew: end the grant without a write
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = w_rr_after;
        end else if (w_xfer) begin
          if (r_beat_cnt == c_BEAT_LAST) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = w_rr_after;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + c_BEAT_W'(1);
          end
        end
        // valid but full: hold grant and beat count
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs: write datapath steered by the registered grant
  always_comb begin
    bus.ready  = '0;
    bus.wr     = w_xfer;
    bus.dout   = '0;
    bus.busy   = 1'b0;
    bus.gnt_id = r_gnt_id;
    if (r_state == ST_GRANT) begin
      bus.busy = 1'b1;
      bus.dout = bus.din_flat[int'(r_gnt_id)*WIDTH +: WIDTH];
      if (w_xfer) begin
        bus.ready[r_gnt_id] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_wr_arbiter
// Brief   : Self-checking bench for fifo_wr_arbiter (NREQ=4/BURST=4 plus a
//           NREQ=3/BURST=1 instance). Producer queues feed the arbiter; an
//           expected-write queue is compared on every write strobe.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
  fifo_wr_arbiter_if #(.NREQ(3), .WIDTH(8)) bus3 ();

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  fifo_wr_arbiter #(.NREQ(3), .WIDTH(8), .BURST(1)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]      src_q [NREQ][$];
  exp_t            exp_q [$];
  logic [NREQ-1:0] acc = '0;

  // Scoreboard monitor: every write must match the next expected word
  initial begin
    exp_t       e;
    logic [3:0] er;
    forever begin
      @(negedge clock);
      if (reset) begin
        acc = '0;
      end else begin
        if (bus.full === 1'b1) begin
          n_checks++;
          if (bus.wr !== 1'b0) begin
            n_errors++;
            $display("FAIL wr_while_full: wr=%b required 0", bus.wr);
          end
        end
        if (bus.wr === 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected_write: gnt=%0d dout=%0h, no write expected", bus.gnt_id, bus.dout);
          end else begin
            e  = exp_q.pop_front();
            er = 4'b0001 << e.id;
            if (bus.gnt_id !== e.id || bus.dout !== e.data || bus.ready !== er) begin
              n_errors++;
              $display("FAIL sb_write: gnt=%0d dout=%0h ready=%b required gnt=%0d dout=%0h ready=%b",
                       bus.gnt_id, bus.dout, bus.ready, e.id, e.data, er);
            end
          end
        end else begin
          n_checks++;
          if (bus.ready !== 4'b0000) begin
            n_errors++;
            $display("FAIL ready_without_wr: ready=%b required 0000", bus.ready);
          end
        end
        acc = bus.ready;
      end
    end
  end

  // Advance one cycle: retire accepted words, then present each queue head
  task automatic tick();
    logic [NREQ-1:0]       v;
    logic [NREQ*WIDTH-1:0] d;
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    v = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) begin
        v[i] = 1'b1;
        d[i*WIDTH +: WIDTH] = src_q[i][0];
      end
    end
    bus.valid    = v;
    bus.din_flat = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    bus.valid     = '0;
    bus.din_flat  = '0;
    bus.full      = 1'b0;
    bus3.valid    = '0;
    bus3.din_flat = '0;
    bus3.full     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.valid    = 4'hF;
    bus.din_flat = 32'hA5A5_A5A5;
    bus.full     = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_checks++;
      if (bus.ready !== 4'b0 || bus.wr !== 1'b0 || bus.dout !== 8'h00 || bus.busy !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_outputs: ready=%b wr=%b dout=%0h busy=%b required all 0",
                 bus.ready, bus.wr, bus.dout, bus.busy);
      end
    end
    // Start a burst, then hit reset mid-grant
    bus.valid    = '0;
    bus.din_flat = '0;
    for (int k = 0; k < 4; k++) src_q[2].push_back(8'(8'h20 + k));
    exp_q.push_back({2'd2, 8'h20});
    exp_q.push_back({2'd2, 8'h21});
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    tick();
    tick();
    #5;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 4'b0 || bus.wr !== 1'b0 || bus.dout !== 8'h00 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async: ready=%b wr=%b dout=%0h busy=%b required all 0",
               bus.ready, bus.wr, bus.dout, bus.busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL reset_pre_burst: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_single();
    bit pw [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    bit pb [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      src_q[2].push_back(8'(8'h20 + k));
      exp_q.push_back({2'd2, 8'(8'h20 + k)});
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      #5;
      n_checks++;
      if (bus.wr !== pw[c] || bus.busy !== pb[c] || (pb[c] && bus.gnt_id !== 2'd2)) begin
        n_errors++;
        $display("FAIL single_cycle%0d: wr=%b busy=%b gnt=%0d required wr=%b busy=%b gnt=2",
                 c, bus.wr, bus.busy, bus.gnt_id, pw[c], pb[c]);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL single_drain: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_rr();
    int       seq [5];
    int       nxt [NREQ];
    logic     ew;
`ifdef FIFO_WR_ARB_PRIO_EN
    seq = '{0, 0, 1, 2, 3};
`else
    seq = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int k = 0; k < 8; k++) src_q[0].push_back(8'(k));
    for (int i = 1; i < NREQ; i++) begin
      for (int k = 0; k < 4; k++) src_q[i].push_back(8'(i * 16 + k));
    end
    for (int i = 0; i < NREQ; i++) nxt[i] = 0;
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < BURST; j++) begin
        exp_q.push_back({2'(seq[b]), 8'(seq[b] * 16 + nxt[seq[b]])});
        nxt[seq[b]]++;
      end
    end
    for (int c = 0; c < 26; c++) begin
      tick();
      #5;
      ew = (c < 25) && (c % 5 != 0);
      n_checks++;
      if (bus.wr !== ew || bus.busy !== ew || (ew && bus.gnt_id !== 2'(seq[c/5]))) begin
        n_errors++;
        $display("FAIL rr_cycle%0d: wr=%b busy=%b gnt=%0d required wr=%b busy=%b gnt=%0d",
                 c, bus.wr, bus.busy, bus.gnt_id, ew, ew, ew ? seq[c/5] : 0);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rr_drain: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_full_stall();
    bit pw [11] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
    bit pb [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      src_q[1].push_back(8'(8'h10 + k));
      exp_q.push_back({2'd1, 8'(8'h10 + k)});
    end
    for (int c = 0; c < 11; c++) begin
      tick();
      bus.full = (c >= 3 && c <= 7);
      #5;
      n_checks++;
      if (bus.wr !== pw[c] || bus.busy !== pb[c] || (pb[c] && bus.gnt_id !== 2'd1)) begin
        n_errors++;
        $display("FAIL stall_cycle%0d: wr=%b busy=%b gnt=%0d required wr=%b busy=%b gnt=1",
                 c, bus.wr, bus.busy, bus.gnt_id, pw[c], pb[c]);
      end
    end
    bus.full = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL stall_drain: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_release();
    bit pw [13] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    bit pb [13] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0};
    int eg;
    do_reset();
    for (int i = 1; i < NREQ; i++) begin
      for (int k = 0; k < 2; k++) begin
        src_q[i].push_back(8'(i * 16 + k));
        exp_q.push_back({2'(i), 8'(i * 16 + k)});
      end
    end
    for (int c = 0; c < 13; c++) begin
      tick();
      #5;
      eg = (c < 4) ? 1 : (c < 8) ? 2 : 3;
      n_checks++;
      if (bus.wr !== pw[c] || bus.busy !== pb[c] || (pb[c] && bus.gnt_id !== 2'(eg))) begin
        n_errors++;
        $display("FAIL release_cycle%0d: wr=%b busy=%b gnt=%0d required wr=%b busy=%b gnt=%0d",
                 c, bus.wr, bus.busy, bus.gnt_id, pw[c], pb[c], eg);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL release_drain: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_burst1();
    logic       ew;
    int         eg;
    logic [2:0] er;
    logic [7:0] ed;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) begin
        bus3.valid    = 3'b111;
        bus3.din_flat = 24'hC2C1C0;
      end
      #5;
      ew = (c % 2 == 1);
`ifdef FIFO_WR_ARB_PRIO_EN
      eg = 0;
`else
      eg = ((c - 1) / 2) % 3;
`endif
      er = ew ? (3'b001 << eg) : 3'b000;
      ed = ew ? 8'(8'hC0 + eg) : 8'h00;
      n_checks++;
      if (bus3.wr !== ew || bus3.ready !== er || bus3.dout !== ed || (ew && bus3.gnt_id !== 2'(eg))) begin
        n_errors++;
        $display("FAIL burst1_cycle%0d: wr=%b ready=%b dout=%0h gnt=%0d required wr=%b ready=%b dout=%0h gnt=%0d",
                 c, bus3.wr, bus3.ready, bus3.dout, bus3.gnt_id, ew, er, ed, eg);
      end
    end
    bus3.valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_full_stall();
    test_release();
    test_burst1();
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
